// File: rtl/frame_sequencer.sv
// frame_sequencer: animation-frame controller for the POV texture path.
// Steps a pending frame index under MMIO control (play/pause, loop/one-shot,
// rate, frame count, single-step) and commits it to the display only on a
// revolution tick so a frame never changes mid-rotation. The texture-ROM
// base offset is tracked incrementally alongside the index (no multiplier).
module frame_sequencer #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int MAX_FRAMES = 16,
    parameter int FRAME_SIZE = 3328,
    parameter int IDX_W      = 8,
    parameter int OFS_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             rev_tick,
    output logic [IDX_W-1:0] frame_idx,
    output logic [OFS_W-1:0] frame_offset,
    output logic             playing,
    output logic             seq_done
);

    localparam int          NF_W       = $clog2(MAX_FRAMES + 1);
    localparam logic [31:0] PERIOD_RST = 32'(CLK_FREQ / 24);

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_PERIOD  = 2'd1;
    localparam logic [1:0] A_NFRAMES = 2'd2;
    localparam logic [1:0] A_STEP    = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t           state_q;
    logic             play_q, loop_q, seq_done_q;
    logic [31:0]      period_q, timer_q;
    logic [NF_W-1:0]  nframes_q;
    logic [IDX_W-1:0] pend_idx_q, frame_idx_q;
    logic [OFS_W-1:0] pend_ofs_q, frame_ofs_q;

    logic             at_last, expire;
    logic [IDX_W-1:0] adv_idx_d;
    logic [OFS_W-1:0] adv_ofs_d;
    logic [31:0]      nf_clamp_d;

    // Advance candidate (wraps to 0 at the last frame), timer expiry and
    // the clamped frame count for an NFRAMES write.
    always_comb begin
        at_last    = (32'(pend_idx_q) == (32'(nframes_q) - 32'd1));
        expire     = (timer_q >= (period_q - 32'd1));
        adv_idx_d  = at_last ? '0 : pend_idx_q + IDX_W'(1);
        adv_ofs_d  = at_last ? '0 : pend_ofs_q + OFS_W'(FRAME_SIZE);
        nf_clamp_d = cfg_wdata;
        if (cfg_wdata == 32'd0)
            nf_clamp_d = 32'd1;
        else if (cfg_wdata > 32'(MAX_FRAMES))
            nf_clamp_d = 32'(MAX_FRAMES);
    end

    // Sequencer FSM, register file and commit stage. Register-write effects
    // are assigned after the timer/advance logic so they win on collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            play_q      <= 1'b0;
            loop_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            period_q    <= PERIOD_RST;
            nframes_q   <= NF_W'(1);
            timer_q     <= '0;
            pend_idx_q  <= '0;
            pend_ofs_q  <= '0;
            frame_idx_q <= '0;
            frame_ofs_q <= '0;
        end else begin
            seq_done_q <= 1'b0;

            // commit samples the pre-advance pending value
            if (rev_tick) begin
                frame_idx_q <= pend_idx_q;
                frame_ofs_q <= pend_ofs_q;
            end

            case (state_q)
                S_RUN: begin
                    if (expire) begin
                        timer_q <= '0;
                        if (at_last && !loop_q) begin
                            state_q    <= S_HOLD;
                            play_q     <= 1'b0;
                            seq_done_q <= 1'b1;
                        end else begin
                            pend_idx_q <= adv_idx_d;
                            pend_ofs_q <= adv_ofs_d;
                        end
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                default: timer_q <= '0;
            endcase

            if (cfg_we) begin
                case (cfg_addr)
                    A_CTRL: begin
                        loop_q     <= cfg_wdata[1];
                        // a CTRL write in RUN always decides the next state,
                        // so a colliding one-shot finish is dropped
                        seq_done_q <= 1'b0;
                        if (cfg_wdata[2]) begin
                            pend_idx_q <= '0;
                            pend_ofs_q <= '0;
                            timer_q    <= '0;
                        end
                        if (cfg_wdata[0] || (state_q == S_HOLD && cfg_wdata[2])) begin
                            state_q <= S_RUN;
                            play_q  <= 1'b1;
                        end else if (state_q == S_RUN) begin
                            state_q <= S_IDLE;
                            play_q  <= 1'b0;
                        end
                    end
                    A_PERIOD: begin
                        period_q <= (cfg_wdata == 32'd0) ? 32'd1 : cfg_wdata;
                        if (state_q == S_RUN)
                            timer_q <= '0;
                    end
                    A_NFRAMES: begin
                        nframes_q <= NF_W'(nf_clamp_d);
                        if (32'(pend_idx_q) >= nf_clamp_d) begin
                            pend_idx_q <= '0;
                            pend_ofs_q <= '0;
                        end
                    end
                    A_STEP: begin
                        // single step always wraps, regardless of loop
                        if (state_q == S_IDLE) begin
                            pend_idx_q <= adv_idx_d;
                            pend_ofs_q <= adv_ofs_d;
                        end
                    end
                endcase
            end
        end
    end

    assign frame_idx    = frame_idx_q;
    assign frame_offset = frame_ofs_q;
    assign playing      = play_q;
    assign seq_done     = seq_done_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed table plus hand-written multi-cycle sequences
// for the frame_sequencer animation controller.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        rev_tick;
    logic [7:0]  frame_idx;
    logic [15:0] frame_offset;
    logic        playing;
    logic        seq_done;

    int n_checks = 0;
    int n_fail   = 0;

    frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .rev_tick    (rev_tick),
        .frame_idx   (frame_idx),
        .frame_offset(frame_offset),
        .playing     (playing),
        .seq_done    (seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        rev;
        logic [7:0]  e_idx;
        logic [15:0] e_ofs;
        logic        e_play;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic pulse_rev();
        @(negedge clk);
        rev_tick = 1'b1;
        @(posedge clk);
        #1;
        rev_tick = 1'b0;
    endtask

    initial begin
        int pulses, pulse_c;
        logic play14, play15;
        logic [7:0] exp_idx;

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; rev_tick = 1'b0;

        //            we    addr  wdata  rev   idx  ofs    play
        tbl[0]  = '{1'b1, 2'd2, 32'd2,  1'b0, 8'd0, 16'd0,    1'b0};
        tbl[1]  = '{1'b1, 2'd3, 32'd0,  1'b0, 8'd0, 16'd0,    1'b0};
        tbl[2]  = '{1'b0, 2'd0, 32'd0,  1'b1, 8'd1, 16'd3328, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 32'd0,  1'b0, 8'd1, 16'd3328, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 32'd0,  1'b1, 8'd0, 16'd0,    1'b0};
        tbl[5]  = '{1'b1, 2'd3, 32'd0,  1'b0, 8'd0, 16'd0,    1'b0};
        tbl[6]  = '{1'b0, 2'd0, 32'd0,  1'b1, 8'd1, 16'd3328, 1'b0};
        tbl[7]  = '{1'b1, 2'd2, 32'd0,  1'b0, 8'd1, 16'd3328, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 32'd0,  1'b1, 8'd0, 16'd0,    1'b0};
        tbl[9]  = '{1'b1, 2'd3, 32'd0,  1'b0, 8'd0, 16'd0,    1'b0};
        tbl[10] = '{1'b0, 2'd0, 32'd0,  1'b1, 8'd0, 16'd0,    1'b0};
        tbl[11] = '{1'b1, 2'd2, 32'd40, 1'b0, 8'd0, 16'd0,    1'b0};
        tbl[12] = '{1'b1, 2'd3, 32'd0,  1'b0, 8'd0, 16'd0,    1'b0};
        tbl[13] = '{1'b0, 2'd0, 32'd0,  1'b1, 8'd1, 16'd3328, 1'b0};
        tbl[14] = '{1'b1, 2'd0, 32'd4,  1'b0, 8'd1, 16'd3328, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 32'd0,  1'b1, 8'd0, 16'd0,    1'b0};
        tbl[16] = '{1'b1, 2'd0, 32'd1,  1'b0, 8'd0, 16'd0,    1'b1};
        tbl[17] = '{1'b1, 2'd0, 32'd0,  1'b0, 8'd0, 16'd0,    1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_idx", 32'(frame_idx), 0);
        chk("rst_ofs", 32'(frame_offset), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_seq_done", 32'(seq_done), 0);
        @(negedge clk);
        reset = 1'b0;

        // single-cycle vectors: step, clamp, restart, play status
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
            rev_tick = tbl[i].rev;
            @(posedge clk);
            #1;
            cfg_we = 1'b0; rev_tick = 1'b0;
            chk($sformatf("tbl%0d_idx", i), 32'(frame_idx), 32'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_ofs", i), 32'(frame_offset), 32'(tbl[i].e_ofs));
            chk($sformatf("tbl%0d_play", i), 32'(playing), 32'(tbl[i].e_play));
        end

        // NFRAMES=16 after clamp: 15 steps reach the top slot, one more wraps
        repeat (15) wr(2'd3, 32'd0);
        pulse_rev();
        chk("step15_idx", 32'(frame_idx), 15);
        chk("step15_ofs", 32'(frame_offset), 49920);
        wr(2'd3, 32'd0);
        pulse_rev();
        chk("step16_wrap_idx", 32'(frame_idx), 0);

        // looping playback: advances every 10 cycles, tick mid-period
        wr(2'd2, 32'd4);
        wr(2'd1, 32'd10);
        wr(2'd0, 32'd3);
        chk("loop_playing", 32'(playing), 1);
        repeat (4) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k != 0) repeat (9) @(posedge clk);
            pulse_rev();
            chk($sformatf("loop%0d_idx", k), 32'(frame_idx), 32'(k % 4));
            chk($sformatf("loop%0d_ofs", k), 32'(frame_offset), 32'((k % 4) * 3328));
        end
        wr(2'd0, 32'd0);

        // one-shot: three frames, PERIOD=5, finishes on cycle 15
        wr(2'd0, 32'd4);
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd5);
        wr(2'd0, 32'd1);
        pulses = 0; pulse_c = 0; play14 = 1'b0; play15 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (seq_done) begin pulses++; pulse_c = c; end
            if (c == 14) play14 = playing;
            if (c == 15) play15 = playing;
        end
        chk("oneshot_pulses", 32'(pulses), 1);
        chk("oneshot_pulse_cycle", 32'(pulse_c), 15);
        chk("oneshot_play_before", 32'(play14), 1);
        chk("oneshot_play_drop", 32'(play15), 0);
        pulse_rev();
        chk("oneshot_hold_idx", 32'(frame_idx), 2);
        chk("oneshot_hold_ofs", 32'(frame_offset), 6656);
        wr(2'd0, 32'd3);
        repeat (6) @(posedge clk);
        pulse_rev();
        chk("oneshot_resume_wrap", 32'(frame_idx), 0);

        // tear-free commit: PERIOD=3, tick every 100 cycles; cycle 300 is
        // also an advance edge so the commit must take the old pending value
        wr(2'd0, 32'd4);
        wr(2'd2, 32'd16);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd3);
        exp_idx = 8'd0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            rev_tick = (c % 100 == 0);
            @(posedge clk);
            #1;
            rev_tick = 1'b0;
            if (c % 100 == 0) exp_idx = 8'(((c - 1) / 3) % 16);
            chk($sformatf("tearfree_c%0d", c), 32'(frame_idx), 32'(exp_idx));
        end
        chk("tearfree_ofs", 32'(frame_offset), 3 * 3328);

        // restart coincident with an advance edge (cycle 303): restart wins
        repeat (2) @(posedge clk);
        wr(2'd0, 32'd7);
        pulse_rev();
        chk("restart_vs_adv", 32'(frame_idx), 0);

        // reset mid-RUN with frame 5 displayed
        wr(2'd0, 32'd4);
        repeat (5) wr(2'd3, 32'd0);
        pulse_rev();
        chk("pre_reset_idx", 32'(frame_idx), 5);
        chk("pre_reset_ofs", 32'(frame_offset), 16640);
        wr(2'd0, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_idx", 32'(frame_idx), 0);
        chk("async_rst_ofs", 32'(frame_offset), 0);
        chk("async_rst_playing", 32'(playing), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_playing", 32'(playing), 0);
        for (int k = 0; k < 3; k++) begin
            pulse_rev();
            chk($sformatf("post_rst_tick%0d", k), 32'(frame_idx), 0);
        end

        // PERIOD=0 is stored as 1: one advance per cycle
        wr(2'd2, 32'd16);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd3);
        repeat (4) @(posedge clk);
        pulse_rev();
        chk("period0_a", 32'(frame_idx), 4);
        pulse_rev();
        chk("period0_b", 32'(frame_idx), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
